// File: rtl/dds_sequencer.sv
// rtl/dds_sequencer.sv - DDS phase accumulator and glitch-free config sequencer (optional DDS_PHASE_OFFSET_EN)
`ifndef ROM_PHASE_BIT
`define ROM_PHASE_BIT 10
`endif

module dds_sequencer #(
  parameter int ACC_BIT     = 32,
  parameter int PHASE_BIT   = `ROM_PHASE_BIT,
  parameter int ROM_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [ACC_BIT-1:0]   cfg_tuning,
  input  logic [1:0]           cfg_shape,
  input  logic                 cfg_enable,
`ifdef DDS_PHASE_OFFSET_EN
  input  logic [PHASE_BIT-1:0] cfg_offset,
`endif
  output logic [PHASE_BIT-1:0] phase,
  output logic [1:0]           shape,
  output logic                 wrap,
  output logic                 active
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PEND = 2'd2} state_t;

  state_t             state, state_n;
  logic [ACC_BIT-1:0] acc, acc_n;
  logic [ACC_BIT-1:0] tuning, tuning_n;
  logic [1:0]         shape_reg, shape_n;
  logic [ACC_BIT-1:0] sh_tuning, sh_tuning_n;
  logic [1:0]         sh_shape, sh_shape_n;
  logic               sh_enable, sh_enable_n;
  logic               wrap_n;
  logic [ACC_BIT:0]   sum;
  logic               carry;
  logic               accept;
`ifdef DDS_PHASE_OFFSET_EN
  logic [PHASE_BIT-1:0] offset_reg, offset_n;
  logic [PHASE_BIT-1:0] sh_offset, sh_offset_n;
`endif

  assign sum       = {1'b0, acc} + {1'b0, tuning};
  assign carry     = sum[ACC_BIT];
  assign cfg_ready = (state != PEND);
  assign accept    = cfg_valid & cfg_ready;

`ifdef DDS_PHASE_OFFSET_EN
  assign phase = acc[ACC_BIT-1 -: PHASE_BIT] + offset_reg;
`else
  assign phase = acc[ACC_BIT-1 -: PHASE_BIT];
`endif

  // Next-state and next-register values; a pending config lands at the carry edge
  // (or immediately when a zero tuning word means no carry will ever come).
  always_comb begin
    state_n     = state;
    acc_n       = acc;
    tuning_n    = tuning;
    shape_n     = shape_reg;
    sh_tuning_n = sh_tuning;
    sh_shape_n  = sh_shape;
    sh_enable_n = sh_enable;
    wrap_n      = 1'b0;
`ifdef DDS_PHASE_OFFSET_EN
    offset_n    = offset_reg;
    sh_offset_n = sh_offset;
`endif
    case (state)
      IDLE: begin
        acc_n = '0;
        if (accept) begin
          shape_n = cfg_shape;
`ifdef DDS_PHASE_OFFSET_EN
          offset_n = cfg_offset;
`endif
          if (cfg_enable) begin
            tuning_n = cfg_tuning;
            state_n  = RUN;
          end
        end
      end
      RUN: begin
        acc_n  = sum[ACC_BIT-1:0];
        wrap_n = carry;
        if (accept) begin
          sh_tuning_n = cfg_tuning;
          sh_shape_n  = cfg_shape;
          sh_enable_n = cfg_enable;
`ifdef DDS_PHASE_OFFSET_EN
          sh_offset_n = cfg_offset;
`endif
          state_n = PEND;
        end
      end
      PEND: begin
        acc_n  = sum[ACC_BIT-1:0];
        wrap_n = carry;
        if (carry || (tuning == '0)) begin
          tuning_n = sh_tuning;
          shape_n  = sh_shape;
`ifdef DDS_PHASE_OFFSET_EN
          offset_n = sh_offset;
`endif
          if (sh_enable) begin
            state_n = RUN;
          end else begin
            state_n = IDLE;
            acc_n   = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any pending shadow config.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      acc       <= '0;
      tuning    <= '0;
      shape_reg <= 2'b00;
      sh_tuning <= '0;
      sh_shape  <= 2'b00;
      sh_enable <= 1'b0;
      wrap      <= 1'b0;
      active    <= 1'b0;
`ifdef DDS_PHASE_OFFSET_EN
      offset_reg <= '0;
      sh_offset  <= '0;
`endif
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      tuning    <= tuning_n;
      shape_reg <= shape_n;
      sh_tuning <= sh_tuning_n;
      sh_shape  <= sh_shape_n;
      sh_enable <= sh_enable_n;
      wrap      <= wrap_n;
      active    <= (state_n != IDLE);
`ifdef DDS_PHASE_OFFSET_EN
      offset_reg <= offset_n;
      sh_offset  <= sh_offset_n;
`endif
    end
  end

  generate
    if (ROM_LATENCY == 0) begin : g_no_delay
      assign shape = shape_reg;
    end else begin : g_delay
      logic [1:0] pipe [ROM_LATENCY];
      // Delay the shape select so it meets the ROM data it belongs to.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < ROM_LATENCY; i++) pipe[i] <= 2'b00;
        end else begin
          pipe[0] <= shape_reg;
          for (int i = 1; i < ROM_LATENCY; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign shape = pipe[ROM_LATENCY-1];
    end
  endgenerate

endmodule

// File: tb/tb_dds_sequencer.sv
// tb/tb_dds_sequencer.sv - self-checking bench for dds_sequencer
module tb_dds_sequencer;
  localparam int ACC_BIT = 8, PHASE_BIT = 4, ROM_LATENCY = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [7:0] cfg_tuning = 8'h00;
  logic [1:0] cfg_shape = 2'b00;
  logic       cfg_enable = 1'b0;
  logic [3:0] cfg_offset = 4'h0;
  logic [3:0] phase;
  logic [1:0] shape;
  logic       wrap;
  logic       active;

  dds_sequencer #(.ACC_BIT(ACC_BIT), .PHASE_BIT(PHASE_BIT), .ROM_LATENCY(ROM_LATENCY)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_tuning(cfg_tuning), .cfg_shape(cfg_shape), .cfg_enable(cfg_enable),
`ifdef DDS_PHASE_OFFSET_EN
    .cfg_offset(cfg_offset),
`endif
    .phase(phase), .shape(shape), .wrap(wrap), .active(active)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: running/pending flags, integer accumulator, shape delay queue.
  bit m_run, m_pend, m_wrap, p_en;
  int m_acc, m_tun, m_shp, m_off, p_tun, p_shp, p_off;
  int shq[$];

  task automatic model_reset();
    m_run = 0; m_pend = 0; m_wrap = 0; p_en = 0;
    m_acc = 0; m_tun = 0; m_shp = 0; m_off = 0;
    p_tun = 0; p_shp = 0; p_off = 0;
    shq = {};
    for (int i = 0; i < ROM_LATENCY; i++) shq.push_back(0);
  endtask

  task automatic model_step();
    int s;
    shq.push_back(m_shp);
    void'(shq.pop_front());
    m_wrap = 0;
    if (!m_run) begin
      m_acc = 0;
      if (cfg_valid) begin
        m_shp = cfg_shape;
        m_off = cfg_offset;
        if (cfg_enable) begin
          m_tun = cfg_tuning;
          m_run = 1;
        end
      end
    end else begin
      s = m_acc + m_tun;
      m_wrap = (s >= 256);
      m_acc = s % 256;
      if (m_pend) begin
        if (m_wrap || m_tun == 0) begin
          m_tun = p_tun; m_shp = p_shp; m_off = p_off; m_pend = 0;
          if (!p_en) begin
            m_run = 0;
            m_acc = 0;
          end
        end
      end else if (cfg_valid) begin
        p_tun = cfg_tuning; p_shp = cfg_shape; p_en = cfg_enable; p_off = cfg_offset;
        m_pend = 1;
      end
    end
  endtask

  task automatic model_check();
    chk("phase", phase, ((m_acc / 16) + m_off) % 16);
    chk("shape", shape, shq[0]);
    chk("wrap", wrap, m_wrap);
    chk("active", active, m_run);
    chk("cfg_ready", cfg_ready, !m_pend);
  endtask

  task automatic tick();
    @(negedge clk);
    model_check();
    @(posedge clk);
    if (rst) model_step();
    #1;
  endtask

  task automatic reset_dut();
    cfg_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic send(input logic [7:0] t, input logic [1:0] s, input logic e, input logic [3:0] o);
    cfg_valid = 1'b1; cfg_tuning = t; cfg_shape = s; cfg_enable = e; cfg_offset = o;
    tick();
    cfg_valid = 1'b0;
  endtask

  typedef struct {
    logic       v;
    logic [7:0] tun;
    logic [1:0] shp;
    logic       en;
    logic [3:0] ph;
    logic [1:0] sh;
    logic       wr;
    logic       act;
    logic       rdy;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // zero tuning word in RUN, then a new word applied without waiting for a wrap
    tbl[0] = '{1'b1, 8'h00, 2'b10, 1'b1, 4'd0, 2'd0, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 8'h00, 2'b00, 1'b0, 4'd0, 2'd0, 1'b0, 1'b1, 1'b1};
    tbl[2] = '{1'b1, 8'h08, 2'b10, 1'b1, 4'd0, 2'd2, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{1'b0, 8'h00, 2'b00, 1'b0, 4'd0, 2'd2, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 2'b00, 1'b0, 4'd0, 2'd2, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 8'h00, 2'b00, 1'b0, 4'd0, 2'd2, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 8'h00, 2'b00, 1'b0, 4'd1, 2'd2, 1'b0, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 8'h00, 2'b00, 1'b0, 4'd1, 2'd2, 1'b0, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 8'h00, 2'b00, 1'b0, 4'd2, 2'd2, 1'b0, 1'b1, 1'b1};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    chk("rst_phase", phase, 0);
    chk("rst_shape", shape, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_active", active, 0);
    chk("rst_ready", cfg_ready, 1);

    for (int i = 0; i < 9; i++) begin
      cfg_valid = tbl[i].v; cfg_tuning = tbl[i].tun; cfg_shape = tbl[i].shp;
      cfg_enable = tbl[i].en; cfg_offset = 4'h0;
      chk("tbl_phase", phase, tbl[i].ph);
      chk("tbl_shape", shape, tbl[i].sh);
      chk("tbl_wrap", wrap, tbl[i].wr);
      chk("tbl_active", active, tbl[i].act);
      chk("tbl_ready", cfg_ready, tbl[i].rdy);
      tick();
    end
    cfg_valid = 1'b0;

    // phase ramp with wrap pulse every 16 cycles
    reset_dut();
    send(8'h10, 2'b01, 1'b1, 4'h0);
    for (int j = 0; j <= 16; j++) begin
      chk("t1_phase", phase, j % 16);
      chk("t1_wrap", wrap, (j == 16));
      if (j == 0) chk("t1_shape0", shape, 0);
      if (j == 1) chk("t1_shape1", shape, 1);
      tick();
    end

    // retune mid-cycle: held off until the wrap
    for (int k = 0; k < 40 && ((m_acc / 16) != 5); k++) tick();
    chk("t2_start_phase", phase, 5);
    send(8'h20, 2'b00, 1'b1, 4'h0);
    for (int k = 6; k <= 15; k++) begin
      chk("t2_phase", phase, k);
      chk("t2_ready", cfg_ready, 0);
      tick();
    end
    chk("t2_wrap_phase", phase, 0);
    chk("t2_wrap", wrap, 1);
    chk("t2_ready_back", cfg_ready, 1);
    chk("t2_old_shape", shape, 1);
    tick();
    chk("t2_phase2", phase, 2);
    chk("t2_new_shape", shape, 0);
    chk("t2_wrap_low", wrap, 0);
    tick();
    chk("t2_phase4", phase, 4);

    // disable request stops at the wrap
    send(8'h20, 2'b00, 1'b0, 4'h0);
    for (int k = 0; k < 20; k++) begin
      if (wrap === 1'b1) break;
      tick();
    end
    chk("t3_wrap_seen", wrap, 1);
    chk("t3_active", active, 0);
    chk("t3_phase", phase, 0);
    chk("t3_ready", cfg_ready, 1);
    tick();
    chk("t3_idle_active", active, 0);
    chk("t3_idle_phase", phase, 0);
    chk("t3_idle_wrap", wrap, 0);

    // asynchronous reset while a config is pending
    send(8'h10, 2'b01, 1'b1, 4'h0);
    repeat (3) tick();
    send(8'h30, 2'b10, 1'b1, 4'h0);
    tick();
    chk("t5_pend_ready", cfg_ready, 0);
    #3;
    rst = 1'b0;
    #1;
    chk("t5_rst_phase", phase, 0);
    chk("t5_rst_shape", shape, 0);
    chk("t5_rst_wrap", wrap, 0);
    chk("t5_rst_active", active, 0);
    chk("t5_rst_ready", cfg_ready, 1);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (20) tick();
    chk("t5_after_active", active, 0);
    chk("t5_after_phase", phase, 0);
    chk("t5_after_shape", shape, 0);

`ifdef DDS_PHASE_OFFSET_EN
    // phase offset added after the accumulator, wrap still from the carry
    reset_dut();
    send(8'h10, 2'b00, 1'b1, 4'hE);
    for (int j = 0; j <= 16; j++) begin
      chk("t6_phase", phase, (j + 14) % 16);
      chk("t6_wrap", wrap, (j == 16));
      tick();
    end
`endif

    // randomized traffic against the model
    reset_dut();
    for (int n = 0; n < 400; n++) begin
      int r;
      if ($urandom_range(0, 99) == 0) reset_dut();
      cfg_valid = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 7);
      if (r == 0) cfg_tuning = 8'h00;
      else if (r < 3) cfg_tuning = 8'($urandom_range(0, 3) * 8'h40);
      else cfg_tuning = 8'($urandom_range(0, 255));
      cfg_shape = 2'($urandom_range(0, 3));
      cfg_enable = ($urandom_range(0, 4) != 0);
`ifdef DDS_PHASE_OFFSET_EN
      cfg_offset = 4'($urandom_range(0, 15));
`endif
      tick();
    end
    cfg_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dds_sequencer.md
Name: dds_sequencer

Overview:
Runtime controller for the DDS phase-to-amplitude path. It owns the phase accumulator and produces the phase and shape selection that drive the sine/triangle/square ROM bank and its output mux. Configuration (tuning word, shape, enable) is accepted over a valid/ready handshake. Changes are applied only at a phase wrap, so output waveforms switch without glitches. The shape select is delayed to match ROM read latency, so the mux never pairs a sample with the wrong ROM.

Parameters:
ACC_BIT, 32, phase accumulator width; tuning word width
PHASE_BIT, `ROM_PHASE_BIT, phase output width = ROM address width; must be <= ACC_BIT
ROM_LATENCY, 1, ROM read latency in cycles; shape output delay, 0..4

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
cfg_valid  input  1  configuration request
cfg_ready  output  1  configuration can be accepted
cfg_tuning  input  ACC_BIT  frequency tuning word
cfg_shape  input  2  00 sine, 01 triangle, 1x square
cfg_enable  input  1  1 run, 0 stop
phase  output  PHASE_BIT  ROM address = acc[ACC_BIT-1 -: PHASE_BIT]
shape  output  2  shape select for ROM output mux, latency-aligned
wrap  output  1  one-cycle pulse on accumulator carry-out
active  output  1  state is RUN or PEND

Behaviour:
- Reset (rst=0, async): acc=0, tuning=0, shape pipeline all 00, state IDLE, shadow registers 0, wrap=0, active=0. cfg_ready=1.
- Accept condition: cfg_valid & cfg_ready. cfg_ready = (state != PEND), combinational from state.
- IDLE:
  - acc held at 0, phase=0.
  - Accept with enable=1: load tuning and shape, acc=0, go to RUN next cycle.
  - Accept with enable=0: load shape only, stay in IDLE.
- RUN:
  - acc <= acc + tuning each cycle, modulo 2^ACC_BIT.
  - wrap=1 in the cycle after a carry-out is registered, aligned with the post-wrap phase.
  - Accept: capture cfg into shadow registers, go to PEND.
- PEND:
  - acc keeps advancing with the old tuning.
  - On the cycle the carry occurs: new tuning is used from the next add, and the new shape enters the pipeline at the same edge as the post-wrap phase.
  - If shadow enable=1: go to RUN and keep acc continuous (no reset).
  - If shadow enable=0: acc<=0, go to IDLE.
- PEND with current tuning==0: a wrap can never occur, so the shadow config is applied on the next edge (no deadlock).
- Shape alignment: the shape register value is delayed ROM_LATENCY cycles before driving `shape`. With ROM_LATENCY=0 the shape register drives the output directly.
- cfg_valid held high while cfg_ready=0: no accept. The request is taken on the first cycle cfg_ready returns to 1.
- A cfg_valid in the same cycle as a PEND wrap is not accepted, because cfg_ready=0 that cycle.
- Reset mid-operation: immediate return to reset values. The pending shadow config is discarded.
- active is registered from next state and is high in RUN and PEND.

Optional Feature:
Macro DDS_PHASE_OFFSET_EN.
- Defined: adds input cfg_offset [PHASE_BIT-1:0], captured alongside the other cfg fields and applied at the same point (immediately in IDLE, at wrap from PEND).
  - phase = acc top bits + offset, modulo 2^PHASE_BIT.
  - Offset register resets to 0.
  - wrap still derives from the accumulator carry, not the offset sum.
- Undefined: no port, no adder, phase = acc top bits.

Test Plan:
All scenarios use ACC_BIT=8, PHASE_BIT=4, ROM_LATENCY=1.
1. Reset, then cfg {tuning=0x10, shape=01, enable=1} -> phase counts 0,1,..,15,0; wrap high exactly when phase returns to 0 (every 16 cycles); shape=01 one cycle after the first phase=0.
2. In RUN with tuning=0x10 at phase=5, cfg {tuning=0x20, shape=00} -> cfg_ready=0 until wrap; phase continues 6..15; after wrap phase steps 0,2,4; shape changes 01->00 one cycle after the post-wrap phase 0.
3. In RUN, cfg {enable=0} -> at wrap acc=0, active=0, phase stays 0, cfg_ready=1.
4. Enter RUN with tuning=0x00, then cfg {tuning=0x08, enable=1} -> applied on the next edge without waiting for a wrap; phase advances 1 every 2 cycles.
5. rst asserted while in PEND -> outputs reset asynchronously; after release, state IDLE and the shadow config is not applied.
6. With DDS_PHASE_OFFSET_EN defined: tuning=0x10, offset=0xE -> phase sequence 14,15,0,1; wrap fires when the accumulator top bits equal 0 (phase=14).
